// File: rtl/parity_frame_ctrl_pkg.sv
// Purpose: shared constants for the serial parity frame receiver.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package parity_frame_ctrl_pkg;

  // FSM state encoding (3-bit, legacy-compatible constants)
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DATA   = 3'd1;
  localparam logic [2:0] PARITY = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] BREAK  = 3'd4;

  // Default number of data bits per frame
  localparam int DEF_DATA_BITS = 8;

  // Parity sense: value the accumulator starts from
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_frame_ctrl_acc.sv
// Purpose: serial parity toggle register with synchronous load and enable.
// Latency: parity reflects a bit one clock after it is presented with i_en high.
// Backpressure: none; i_en gates accumulation, i_load wins over i_en.
//
// Ports:
//   i_clock    - clock, rising edge
//   i_reset_n  - asynchronous active-low reset (register returns to RST_VAL)
//   i_load     - synchronous load of i_load_val
//   i_load_val - value loaded when i_load is high
//   i_en       - accumulate i_bit this cycle
//   i_bit      - serial bit in
//   o_parity   - running parity (XOR of loaded value and accepted bits)
module parity_acc
  import parity_frame_ctrl_pkg::*;
#(
  parameter logic RST_VAL = PAR_EVEN
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_load,
  input  logic i_load_val,
  input  logic i_en,
  input  logic i_bit,
  output logic o_parity
);

  logic r_par;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_par <= RST_VAL;
    end else if (i_load) begin
      r_par <= i_load_val;
    end else if (i_en) begin
      r_par <= r_par ^ i_bit;
    end
  end

  assign o_parity = r_par;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Purpose: serial frame receiver (start, DATA_BITS data LSB first, parity, stop).
// Latency: o_valid pulses one clock after the stop bit is sampled.
// Backpressure: none; the serial line cannot be stalled, results hold until the next o_valid.
//
// Ports:
//   i_clock      - clock, rising edge
//   i_reset_n    - asynchronous active-low reset, aborts any frame in progress
//   i_in         - serial line, idles high
//   o_data       - last received word
//   o_valid      - one-cycle pulse when a frame completes
//   o_parity_err - parity status of the frame flagged by o_valid
//   o_frame_err  - stop-bit status of the frame flagged by o_valid
//   o_busy       - high while a frame is in progress (DATA, PARITY, STOP, BREAK)
module parity_frame_ctrl
  import parity_frame_ctrl_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter bit ODD       = 1'b0
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_in,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int            CW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
  localparam logic          ACC_INIT = ODD ? PAR_ODD : PAR_EVEN;

  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [DATA_BITS-1:0] r_word;
  logic                 r_perr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr_q;
  logic                 r_ferr;

  logic w_acc;
  logic w_load;
  logic w_en;

  // The accumulator is reseeded on every accepted start bit so a previous
  // frame (or an aborted one) never leaks into the next parity result.
  assign w_load = (r_state == IDLE) && !i_in;
  assign w_en   = (r_state == DATA);

  parity_acc #(
    .RST_VAL (ACC_INIT)
  ) u_acc (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_load     (w_load),
    .i_load_val (ACC_INIT),
    .i_en       (w_en),
    .i_bit      (i_in),
    .o_parity   (w_acc)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_word   <= '0;
      r_perr   <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_q <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!i_in) begin
            r_state <= DATA;
            r_cnt   <= '0;
          end
        end
        DATA: begin
          r_word[r_cnt] <= i_in;
          if (r_cnt == LAST_BIT) begin
            r_cnt   <= '0;
            r_state <= PARITY;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PARITY: begin
          // Nonzero means the received parity bit disagrees with the data.
          r_perr  <= w_acc ^ i_in;
          r_state <= STOP;
        end
        STOP: begin
          // Word is delivered whatever the error status.
          r_data   <= r_word;
          r_perr_q <= r_perr;
          r_ferr   <= ~i_in;
          r_valid  <= 1'b1;
          // A low stop bit means the line is in a break; wait for it to
          // rise before looking for another start bit.
          r_state  <= i_in ? IDLE : BREAK;
        end
        BREAK: begin
          if (i_in) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_parity_err = r_perr_q;
  assign o_frame_err  = r_ferr;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_parity_frame_ctrl.sv
module tb_parity_frame_ctrl;

  localparam int N = 3000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       line  = 1'b1;

  logic [7:0] d_e, d_o;
  logic       v_e, v_o, pe_e, pe_o, fe_e, fe_o, b_e, b_o;

  parity_frame_ctrl #(.DATA_BITS(8), .ODD(1'b0)) dut_even (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_in         (line),
    .o_data       (d_e),
    .o_valid      (v_e),
    .o_parity_err (pe_e),
    .o_frame_err  (fe_e),
    .o_busy       (b_e)
  );

  parity_frame_ctrl #(.DATA_BITS(8), .ODD(1'b1)) dut_odd (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_in         (line),
    .o_data       (d_o),
    .o_valid      (v_o),
    .o_parity_err (pe_o),
    .o_frame_err  (fe_o),
    .o_busy       (b_o)
  );

  always #5 clk = ~clk;

  // Cycle-indexed schedule: line/reset driven in cycle c are sampled at the
  // rising edge that ends cycle c; expectations are for outputs seen in cycle c.
  logic       ln  [N];
  logic       rn  [N];
  logic       ev  [N];
  logic       eb  [N];
  logic [7:0] ed  [N];
  logic       epe [N];
  logic       epo [N];
  logic       ef  [N];
  int         cur;

  int checks   = 0;
  int failures = 0;

  // Hand-computed expectations for the directed frames
  int         pin_cyc [$];
  logic [7:0] pin_dat [$];
  logic       pin_pe  [$];
  logic       pin_po  [$];
  logic       pin_fe  [$];

  task automatic chk1(string nm, int c, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0b expected=%0b", nm, c, act, exp);
    end
  endtask

  task automatic chk8(string nm, int c, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, c, act, exp);
    end
  endtask

  task automatic idle(int n);
    cur += n;
  endtask

  task automatic pin(logic [7:0] d, logic pe, logic po, logic fe);
    pin_cyc.push_back(cur + 11);
    pin_dat.push_back(d);
    pin_pe.push_back(pe);
    pin_po.push_back(po);
    pin_fe.push_back(fe);
  endtask

  // One frame starting at cur. low = extra low cycles after a low stop bit;
  // abort >= 0 pulses reset during that data bit.
  task automatic frame(logic [7:0] d, logic p, logic st, int low, int abort);
    int s;
    int ones;
    s = cur;
    ln[s] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (abort == i) begin
        rn[s + 1 + i] = 1'b0;
        rn[s + 2 + i] = 1'b0;
        cur = s + 4 + i;
        return;
      end
      ln[s + 1 + i] = d[i];
      eb[s + 1 + i] = 1'b1;
    end
    ln[s + 9]  = p;
    eb[s + 9]  = 1'b1;
    ln[s + 10] = st;
    eb[s + 10] = 1'b1;
    ones = $countones(d) + int'(p);
    ev[s + 11]  = 1'b1;
    ed[s + 11]  = d;
    epe[s + 11] = (ones % 2) != 0;
    epo[s + 11] = (ones % 2) == 0;
    ef[s + 11]  = !st;
    if (st) begin
      cur = s + 11;
    end else begin
      for (int k = 0; k < low; k++) begin
        ln[s + 11 + k] = 1'b0;
        eb[s + 11 + k] = 1'b1;
      end
      eb[s + 11 + low] = 1'b1;
      cur = s + 12 + low;
    end
  endtask

  initial begin
    logic [7:0] hd;
    logic       hpe, hpo, hf;
    int         ab;

    for (int i = 0; i < N; i++) begin
      ln[i] = 1'b1; rn[i] = 1'b1; ev[i] = 1'b0; eb[i] = 1'b0;
      ed[i] = 8'h00; epe[i] = 1'b0; epo[i] = 1'b0; ef[i] = 1'b0;
    end
    rn[0] = 1'b0; rn[1] = 1'b0; rn[2] = 1'b0;
    cur = 3;

    idle(20);
    pin(8'hA5, 1'b0, 1'b1, 1'b0); frame(8'hA5, 1'b0, 1'b1, 0, -1); idle(2);
    pin(8'hA5, 1'b1, 1'b0, 1'b0); frame(8'hA5, 1'b1, 1'b1, 0, -1); idle(2);
    pin(8'h66, 1'b0, 1'b1, 1'b1); frame(8'h66, 1'b0, 1'b0, 5, -1);
    pin(8'h3C, 1'b0, 1'b1, 1'b0); frame(8'h3C, 1'b0, 1'b1, 0, -1); idle(1);
    pin(8'h01, 1'b0, 1'b1, 1'b0); frame(8'h01, 1'b1, 1'b1, 0, -1);
    pin(8'hFF, 1'b0, 1'b1, 1'b0); frame(8'hFF, 1'b0, 1'b1, 0, -1); idle(2);
    frame(8'h77, 1'b0, 1'b1, 0, 4);
    pin(8'h5A, 1'b0, 1'b1, 1'b0); frame(8'h5A, 1'b0, 1'b1, 0, -1); idle(2);

    while (cur < N - 40) begin
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      frame(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
            int'($urandom_range(0, 4)), ab);
      idle(int'($urandom_range(0, 3)));
    end
    idle(4);

    hd = 8'h00; hpe = 1'b0; hpo = 1'b0; hf = 1'b0;
    for (int c = 0; c < cur; c++) begin
      @(posedge clk);
      #1;
      rst_n = rn[c];
      line  = ln[c];
      @(negedge clk);
      if (!rn[c]) begin
        hd = 8'h00; hpe = 1'b0; hpo = 1'b0; hf = 1'b0;
      end else if (ev[c]) begin
        hd = ed[c]; hpe = epe[c]; hpo = epo[c]; hf = ef[c];
      end
      chk1("valid_even",  c, v_e,  rn[c] & ev[c]);
      chk1("valid_odd",   c, v_o,  rn[c] & ev[c]);
      chk1("busy_even",   c, b_e,  rn[c] & eb[c]);
      chk1("busy_odd",    c, b_o,  rn[c] & eb[c]);
      chk8("data_even",   c, d_e,  hd);
      chk8("data_odd",    c, d_o,  hd);
      chk1("perr_even",   c, pe_e, hpe);
      chk1("perr_odd",    c, pe_o, hpo);
      chk1("ferr_even",   c, fe_e, hf);
      chk1("ferr_odd",    c, fe_o, hf);
      if (pin_cyc.size() > 0 && pin_cyc[0] == c) begin
        chk1("pin_valid",     c, v_e,  1'b1);
        chk8("pin_data",      c, d_e,  pin_dat[0]);
        chk1("pin_perr_even", c, pe_e, pin_pe[0]);
        chk1("pin_perr_odd",  c, pe_o, pin_po[0]);
        chk1("pin_ferr",      c, fe_e, pin_fe[0]);
        void'(pin_cyc.pop_front());
        void'(pin_dat.pop_front());
        void'(pin_pe.pop_front());
        void'(pin_po.pop_front());
        void'(pin_fe.pop_front());
      end
    end
    chk8("pins_unvisited", cur, 8'(pin_cyc.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
